// File: rtl/fir_complex_decim.sv
// Complex-coefficient decimating FIR filter between four FIFOs.
// I/Q samples are popped in lock-step into a shared delay line. Every DECIM
// pops the filter runs TAPS multiply-accumulate cycles, one tap per cycle,
// and pushes one real/imag result pair.
// Build option: define FIR_COMPLEX_SATURATE_EN to clamp results to the
// DATA_WIDTH range instead of wrapping.
module fir_complex_decim #(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 32,
  parameter int TAPS        = 20,
  parameter int DECIM       = 8,
  parameter int FRAC_BITS   = 10,
  parameter logic [TAPS-1:0][COEFF_WIDTH-1:0] REAL_COEFF = '0,
  parameter logic [TAPS-1:0][COEFF_WIDTH-1:0] IMAG_COEFF = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_in,
  input  logic                  i_empty,
  output logic                  i_rd_en,
  input  logic [DATA_WIDTH-1:0] q_in,
  input  logic                  q_empty,
  output logic                  q_rd_en,
  output logic [DATA_WIDTH-1:0] real_out,
  output logic                  real_wr_en,
  input  logic                  real_full,
  output logic [DATA_WIDTH-1:0] imag_out,
  output logic                  imag_wr_en,
  input  logic                  imag_full
);

  localparam int ACC_W = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS) + 1;
  localparam int TAP_W = $clog2(TAPS);
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  // Clamp limits expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [TAP_W-1:0]              tap_q, tap_d;
  logic signed [ACC_W-1:0]       acc_r_q, acc_r_d, acc_i_q, acc_i_d;
  logic [DATA_WIDTH-1:0]         real_q, real_d, imag_q, imag_d;
  logic signed [DATA_WIDTH-1:0]  xi_q [TAPS];
  logic signed [DATA_WIDTH-1:0]  xq_q [TAPS];

  logic                          pop;
  logic                          push;
  logic signed [ACC_W-1:0]       xi_ext, xq_ext, cr_ext, ci_ext;
  logic signed [ACC_W-1:0]       term_r, term_i;

  // Scale accumulator back to sample width: arithmetic shift, then wrap or clamp.
  function automatic logic [DATA_WIDTH-1:0] scale_result(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    logic [DATA_WIDTH-1:0]   res;
    shifted = acc >>> FRAC_BITS;
    res     = shifted[DATA_WIDTH-1:0];
`ifdef FIR_COMPLEX_SATURATE_EN
    if (shifted > SAT_MAX) begin
      res = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      res = SAT_MIN[DATA_WIDTH-1:0];
    end
`endif
    return res;
  endfunction

  // Both FIFOs must have data; I and Q are always popped together.
  assign pop     = (state_q == LOAD) && !i_empty && !q_empty;
  assign push    = (state_q == WRITE) && !real_full && !imag_full;
  assign i_rd_en = pop;
  assign q_rd_en = pop;
  assign real_wr_en = push;
  assign imag_wr_en = push;
  assign real_out   = real_q;
  assign imag_out   = imag_q;

  // Current tap operands, sign-extended so the full complex product fits the accumulator.
  always_comb begin
    xi_ext = ACC_W'(xi_q[tap_q]);
    xq_ext = ACC_W'(xq_q[tap_q]);
    cr_ext = ACC_W'($signed(REAL_COEFF[tap_q]));
    ci_ext = ACC_W'($signed(IMAG_COEFF[tap_q]));
    term_r = (xi_ext * cr_ext) - (xq_ext * ci_ext);
    term_i = (xq_ext * cr_ext) + (xi_ext * ci_ext);
  end

  // Next-state logic: sample counting, tap sequencing, accumulation and output capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tap_d   = tap_q;
    acc_r_d = acc_r_q;
    acc_i_d = acc_i_q;
    real_d  = real_q;
    imag_d  = imag_q;
    case (state_q)
      LOAD: begin
        if (pop) begin
          if (cnt_q == CNT_W'(DECIM - 1)) begin
            cnt_d   = '0;
            tap_d   = '0;
            acc_r_d = '0;
            acc_i_d = '0;
            state_d = MAC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      MAC: begin
        acc_r_d = acc_r_q + term_r;
        acc_i_d = acc_i_q + term_i;
        if (tap_q == TAP_W'(TAPS - 1)) begin
          // Result is captured on entry to WRITE so it is stable while stalled.
          real_d  = scale_result(acc_r_d);
          imag_d  = scale_result(acc_i_d);
          state_d = WRITE;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      WRITE: begin
        if (push) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control, accumulator and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      tap_q   <= '0;
      acc_r_q <= '0;
      acc_i_q <= '0;
      real_q  <= '0;
      imag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
      acc_r_q <= acc_r_d;
      acc_i_q <= acc_i_d;
      real_q  <= real_d;
      imag_q  <= imag_d;
    end
  end

  // Delay line: newest sample in slot 0, frozen except on a pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        xi_q[k] <= '0;
        xq_q[k] <= '0;
      end
    end else if (pop) begin
      xi_q[0] <= i_in;
      xq_q[0] <= q_in;
      for (int k = 1; k < TAPS; k++) begin
        xi_q[k] <= xi_q[k-1];
        xq_q[k] <= xq_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_fir_complex_decim.sv
// Scoreboard bench for fir_complex_decim: two instances (no decimation with a
// mixed real/imag tap set, and DECIM=8 with unit taps). Stimulus pushes
// samples into FIFO models and expected pairs into queues; one monitor
// process checks every handshake against those queues.
module tb_fir_complex_decim;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int TAPS = 4;
  localparam int FRAC = 10;

  // Index 0 is the rightmost element (newest sample).
  localparam logic [TAPS-1:0][CW-1:0] A_R = {16'd0, 16'd0, 16'd512, 16'd1024};
  localparam logic [TAPS-1:0][CW-1:0] A_I = {16'd1024, 16'd0, 16'd0, 16'd0};
  localparam logic [TAPS-1:0][CW-1:0] B_R = {16'd1024, 16'd1024, 16'd1024, 16'd1024};
  localparam logic [TAPS-1:0][CW-1:0] B_I = '0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- instance A: DECIM=1 ----------------
  logic          a_reset = 1'b1;
  logic [DW-1:0] a_i_in, a_q_in, a_real_out, a_imag_out;
  logic          a_i_empty, a_q_empty, a_i_rd_en, a_q_rd_en;
  logic          a_real_wr_en, a_imag_wr_en;
  logic          a_real_full = 1'b0;
  logic          a_q_block   = 1'b0;
  logic [DW-1:0] a_src_i [64];
  logic [DW-1:0] a_src_q [64];
  logic [5:0]    a_wr_ptr = '0;
  logic [5:0]    a_rd_ptr = '0;

  assign a_i_in    = a_src_i[a_rd_ptr];
  assign a_q_in    = a_src_q[a_rd_ptr];
  assign a_i_empty = (a_rd_ptr == a_wr_ptr);
  assign a_q_empty = a_i_empty | a_q_block;

  always @(posedge clock) if (a_i_rd_en) a_rd_ptr <= a_rd_ptr + 6'd1;

  fir_complex_decim #(
    .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .TAPS(TAPS), .DECIM(1), .FRAC_BITS(FRAC),
    .REAL_COEFF(A_R), .IMAG_COEFF(A_I)
  ) dut_a (
    .clock(clock), .reset(a_reset),
    .i_in(a_i_in), .i_empty(a_i_empty), .i_rd_en(a_i_rd_en),
    .q_in(a_q_in), .q_empty(a_q_empty), .q_rd_en(a_q_rd_en),
    .real_out(a_real_out), .real_wr_en(a_real_wr_en), .real_full(a_real_full),
    .imag_out(a_imag_out), .imag_wr_en(a_imag_wr_en), .imag_full(1'b0)
  );

  // ---------------- instance B: DECIM=8 ----------------
  logic          b_reset = 1'b1;
  logic [DW-1:0] b_i_in, b_q_in, b_real_out, b_imag_out;
  logic          b_i_empty, b_q_empty, b_i_rd_en, b_q_rd_en;
  logic          b_real_wr_en, b_imag_wr_en;
  logic [DW-1:0] b_src_i [64];
  logic [DW-1:0] b_src_q [64];
  logic [5:0]    b_wr_ptr = '0;
  logic [5:0]    b_rd_ptr = '0;

  assign b_i_in    = b_src_i[b_rd_ptr];
  assign b_q_in    = b_src_q[b_rd_ptr];
  assign b_i_empty = (b_rd_ptr == b_wr_ptr);
  assign b_q_empty = b_i_empty;

  always @(posedge clock) if (b_i_rd_en) b_rd_ptr <= b_rd_ptr + 6'd1;

  fir_complex_decim #(
    .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .TAPS(TAPS), .DECIM(8), .FRAC_BITS(FRAC),
    .REAL_COEFF(B_R), .IMAG_COEFF(B_I)
  ) dut_b (
    .clock(clock), .reset(b_reset),
    .i_in(b_i_in), .i_empty(b_i_empty), .i_rd_en(b_i_rd_en),
    .q_in(b_q_in), .q_empty(b_q_empty), .q_rd_en(b_q_rd_en),
    .real_out(b_real_out), .real_wr_en(b_real_wr_en), .real_full(1'b0),
    .imag_out(b_imag_out), .imag_wr_en(b_imag_wr_en), .imag_full(1'b0)
  );

  // ---------------- scoreboard state ----------------
  logic signed [DW-1:0] a_exp_r [$];
  logic signed [DW-1:0] a_exp_i [$];
  logic signed [DW-1:0] b_exp_r [$];
  logic signed [DW-1:0] b_exp_i [$];

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;

  // Flags and point-check requests from the stimulus process.
  logic a_lat_on    = 1'b0;
  logic a_stall_chk = 1'b0;
  logic a_idle_chk  = 1'b0;
  logic pt_valid    = 1'b0;
  int   pt_id       = 0;
  int   pt_exp      = 0;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic push_a(input int i, input int q);
    a_src_i[a_wr_ptr] = DW'(i);
    a_src_q[a_wr_ptr] = DW'(q);
    a_wr_ptr = a_wr_ptr + 6'd1;
  endtask

  task automatic push_b(input int i, input int q);
    b_src_i[b_wr_ptr] = DW'(i);
    b_src_q[b_wr_ptr] = DW'(q);
    b_wr_ptr = b_wr_ptr + 6'd1;
  endtask

  task automatic exp_a(input int r, input int im);
    a_exp_r.push_back(DW'(r));
    a_exp_i.push_back(DW'(im));
  endtask

  task automatic exp_b(input int r, input int im);
    b_exp_r.push_back(DW'(r));
    b_exp_i.push_back(DW'(im));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic point(input int id, input int exp_val);
    pt_id    = id;
    pt_exp   = exp_val;
    pt_valid = 1'b1;
    @(posedge clock);
    #1;
    pt_valid = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic signed [DW-1:0] er, ei, hold_r, hold_i;
    int   a_last_pop, a_writes, b_writes, b_pops, act;
    logic stall_prev;
    a_last_pop = 0; a_writes = 0; b_writes = 0; b_pops = 0; stall_prev = 1'b0;
    hold_r = '0; hold_i = '0;
    forever begin
      @(negedge clock);
      // instance A
      if (a_i_rd_en || a_q_rd_en) begin
        compared++;
        if (a_i_rd_en != a_q_rd_en) begin
          failed++;
          $display("FAIL a_rd_pair: i_rd_en=%0b q_rd_en=%0b, required equal", a_i_rd_en, a_q_rd_en);
        end
        a_last_pop = cyc;
      end
      if (a_reset) begin
        compared++;
        if (a_real_out != 0 || a_imag_out != 0 || a_i_rd_en || a_q_rd_en || a_real_wr_en || a_imag_wr_en) begin
          failed++;
          $display("FAIL a_reset_state: out=(%0d,%0d) rd=%0b%0b wr=%0b%0b, required all 0",
                   $signed(a_real_out), $signed(a_imag_out), a_i_rd_en, a_q_rd_en, a_real_wr_en, a_imag_wr_en);
        end
      end
      if (a_idle_chk) begin
        compared++;
        if (a_i_rd_en || a_q_rd_en || a_real_wr_en || a_imag_wr_en) begin
          failed++;
          $display("FAIL a_q_empty_stall: rd=%0b%0b wr=%0b%0b, required all 0",
                   a_i_rd_en, a_q_rd_en, a_real_wr_en, a_imag_wr_en);
        end
      end
      if (a_stall_chk) begin
        if (!stall_prev) begin
          hold_r = a_real_out;
          hold_i = a_imag_out;
        end
        compared++;
        if (a_real_wr_en || a_imag_wr_en || a_real_out != hold_r || a_imag_out != hold_i) begin
          failed++;
          $display("FAIL a_full_hold: wr=%0b%0b out=(%0d,%0d), required wr=00 out=(%0d,%0d)",
                   a_real_wr_en, a_imag_wr_en, $signed(a_real_out), $signed(a_imag_out), hold_r, hold_i);
        end
      end
      stall_prev = a_stall_chk;
      if (a_real_wr_en || a_imag_wr_en) begin
        a_writes++;
        compared++;
        if (a_exp_r.size() == 0) begin
          failed++;
          $display("FAIL a_unexpected_write: out=(%0d,%0d), required no write",
                   $signed(a_real_out), $signed(a_imag_out));
        end else begin
          er = a_exp_r.pop_front();
          ei = a_exp_i.pop_front();
          if (!(a_real_wr_en && a_imag_wr_en) || $signed(a_real_out) != er || $signed(a_imag_out) != ei) begin
            failed++;
            $display("FAIL a_write%0d: wr=%0b%0b out=(%0d,%0d), required wr=11 out=(%0d,%0d)",
                     a_writes, a_real_wr_en, a_imag_wr_en, $signed(a_real_out), $signed(a_imag_out), er, ei);
          end
        end
        if (a_lat_on) begin
          compared++;
          if (cyc - a_last_pop != TAPS + 1) begin
            failed++;
            $display("FAIL a_latency: %0d cycles, required %0d", cyc - a_last_pop, TAPS + 1);
          end
        end
      end
      // instance B
      if (b_i_rd_en || b_q_rd_en) begin
        compared++;
        if (b_i_rd_en != b_q_rd_en) begin
          failed++;
          $display("FAIL b_rd_pair: i_rd_en=%0b q_rd_en=%0b, required equal", b_i_rd_en, b_q_rd_en);
        end
        b_pops++;
      end
      if (b_reset) begin
        compared++;
        if (b_real_out != 0 || b_imag_out != 0 || b_real_wr_en || b_imag_wr_en) begin
          failed++;
          $display("FAIL b_reset_state: out=(%0d,%0d) wr=%0b%0b, required all 0",
                   $signed(b_real_out), $signed(b_imag_out), b_real_wr_en, b_imag_wr_en);
        end
      end
      if (b_real_wr_en || b_imag_wr_en) begin
        b_writes++;
        compared++;
        if (b_pops != 8) begin
          failed++;
          $display("FAIL b_pops_per_write: %0d pops, required 8", b_pops);
        end
        b_pops = 0;
        compared++;
        if (b_exp_r.size() == 0) begin
          failed++;
          $display("FAIL b_unexpected_write: out=(%0d,%0d), required no write",
                   $signed(b_real_out), $signed(b_imag_out));
        end else begin
          er = b_exp_r.pop_front();
          ei = b_exp_i.pop_front();
          if (!(b_real_wr_en && b_imag_wr_en) || $signed(b_real_out) != er || $signed(b_imag_out) != ei) begin
            failed++;
            $display("FAIL b_write%0d: wr=%0b%0b out=(%0d,%0d), required wr=11 out=(%0d,%0d)",
                     b_writes, b_real_wr_en, b_imag_wr_en, $signed(b_real_out), $signed(b_imag_out), er, ei);
          end
        end
      end
      // point checks requested by the stimulus process
      if (pt_valid) begin
        case (pt_id)
          0:       act = a_writes;
          1:       act = b_writes;
          2:       act = int'($signed(a_real_out));
          3:       act = int'($signed(a_imag_out));
          4:       act = a_exp_r.size();
          default: act = b_exp_r.size();
        endcase
        compared++;
        if (act != pt_exp) begin
          failed++;
          $display("FAIL point%0d: got %0d, required %0d", pt_id, act, pt_exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    step(3);
    a_reset = 1'b0;
    b_reset = 1'b0;
    step(2);

    // identity on newest tap, latency TAPS+1
    a_lat_on = 1'b1;
    push_a(5, -3);  exp_a(5, -3);
    step(10);
    point(0, 1);

    // mixed taps: half-weight tap 1, multiply-by-j on tap 3, negative flooring
    push_a(2, 7);   exp_a(4, 5);
    push_a(-7, 1);  exp_a(-6, 4);
    push_a(-1, 0);  exp_a(-2, 5);
    push_a(3, -4);  exp_a(-5, -2);
    step(30);
    point(0, 5);
    a_lat_on = 1'b0;

    // backpressure: real_full held 10 cycles while in WRITE
    a_real_full = 1'b1;
    push_a(0, 0);   exp_a(0, -9);
    step(7);
    a_stall_chk = 1'b1;
    step(10);
    a_stall_chk = 1'b0;
    a_real_full = 1'b0;
    step(5);
    point(0, 6);

    // Q FIFO empty while I has data: nothing moves
    a_q_block  = 1'b1;
    a_idle_chk = 1'b1;
    push_a(9, 9);   exp_a(9, 8);
    step(10);
    a_idle_chk = 1'b0;
    a_q_block  = 1'b0;
    step(8);
    point(0, 7);

    // reset in the middle of MAC: result discarded, outputs zero
    push_a(100, 100);
    step(3);
    a_reset = 1'b1;
    step(3);
    a_reset = 1'b0;
    step(12);
    point(0, 7);
    point(2, 0);
    point(3, 0);

    // delay line was cleared by reset
    push_a(1, 2);   exp_a(1, 2);
    step(10);
    point(0, 8);
    point(4, 0);

    // decimation by 8 over 32 continuous samples
    for (int n = 1; n <= 32; n++) push_b(n, -n);
    exp_b(26, -26);
    exp_b(58, -58);
    exp_b(90, -90);
    exp_b(122, -122);
    step(60);
    point(1, 4);

    // full-scale inputs on all unit taps
    for (int n = 0; n < 8; n++) push_b(32767, -32768);
`ifdef FIR_COMPLEX_SATURATE_EN
    exp_b(32767, -32768);
`else
    exp_b(-4, 0);
`endif
    step(20);
    point(1, 5);
    point(5, 0);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/fir_complex_decim.md
FIR_COMPLEX_DECIM -- requirements
Module: fir_complex_decim

Interface
REQ-001 Parameter DATA_WIDTH, 32, signed sample width of I/Q inputs and real/imag outputs.
REQ-002 Parameter COEFF_WIDTH, 32, signed coefficient width.
REQ-003 Parameter TAPS, 20, filter length (>=2).
REQ-004 Parameter DECIM, 8, decimation factor (>=1; 1 = no decimation).
REQ-005 Parameter FRAC_BITS, 10, fixed-point fraction bits of coefficients; accumulator result is arithmetically shifted right by FRAC_BITS.
REQ-006 Parameter REAL_COEFF, all zero, [TAPS][COEFF_WIDTH] real coefficients, index 0 applied to newest sample.
REQ-007 Parameter IMAG_COEFF, all zero, [TAPS][COEFF_WIDTH] imaginary coefficients, same ordering.
REQ-008 clock  input  1  rising-edge clock.
REQ-009 reset  input  1  reset, asynchronous, active-high.
REQ-010 i_in  input  DATA_WIDTH  in-phase sample, FIFO read data.
REQ-011 i_empty  input  1  I FIFO empty.
REQ-012 i_rd_en  output  1  I FIFO pop.
REQ-013 q_in  input  DATA_WIDTH  quadrature sample, FIFO read data.
REQ-014 q_empty  input  1  Q FIFO empty.
REQ-015 q_rd_en  output  1  Q FIFO pop.
REQ-016 real_out  output  DATA_WIDTH  real part of filtered sample.
REQ-017 real_wr_en  output  1  real FIFO push.
REQ-018 real_full  input  1  real FIFO full.
REQ-019 imag_out  output  DATA_WIDTH  imaginary part of filtered sample.
REQ-020 imag_wr_en  output  1  imag FIFO push.
REQ-021 imag_full  input  1  imag FIFO full.

Function
REQ-022 FSM states LOAD, MAC, WRITE; reset state LOAD.
REQ-023 LOAD: when i_empty=0 and q_empty=0, assert i_rd_en and q_rd_en together for one cycle, shift (i_in,q_in) into delay-line slot 0, older samples move up one slot, slot TAPS-1 discarded; otherwise both rd_en low.
REQ-024 I and Q are never popped independently; one empty stalls both.
REQ-025 Sample counter counts pops modulo DECIM; on the pop that brings it to DECIM, counter clears and FSM enters MAC next cycle; otherwise stays in LOAD.
REQ-026 MAC: one tap per cycle, k=0..TAPS-1, exactly TAPS cycles; accumulators cleared on MAC entry.
REQ-027 Per tap: acc_r += x_i[k]*REAL_COEFF[k] - x_q[k]*IMAG_COEFF[k]; acc_i += x_q[k]*REAL_COEFF[k] + x_i[k]*IMAG_COEFF[k]; all signed.
REQ-028 Accumulators are DATA_WIDTH+COEFF_WIDTH+clog2(TAPS)+1 bits; no internal overflow.
REQ-029 After tap TAPS-1, FSM enters WRITE; outputs = accumulators >>> FRAC_BITS, truncated to DATA_WIDTH (wrap) unless REQ-037 applies.
REQ-030 WRITE: when real_full=0 and imag_full=0, assert real_wr_en and imag_wr_en together for one cycle with outputs valid that cycle, then return to LOAD; else hold outputs, wr_en low, stay in WRITE.
REQ-031 Latency: from the DECIM-th pop edge to wr_en asserted = TAPS+1 cycles with no backpressure.
REQ-032 No pops during MAC or WRITE; delay line frozen.
REQ-033 real_out/imag_out hold last written value outside WRITE.

Reset
REQ-034 Reset asynchronous, active-high; immediately forces FSM to LOAD, sample counter 0, delay line and accumulators 0.
REQ-035 During/after reset: i_rd_en, q_rd_en, real_wr_en, imag_wr_en = 0; real_out, imag_out = 0.
REQ-036 Reset mid-MAC or mid-WRITE discards the pending result; no write emitted.

Configuration
REQ-037 Macro FIR_COMPLEX_SATURATE_EN: defined -> shifted result clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; undefined -> two's-complement truncation (wrap).

Verification
REQ-038 TAPS=4, DECIM=1, REAL_COEFF[0]=1<<FRAC_BITS, others 0, input (5,-3) -> output (5,-3), wr_en exactly TAPS+1 cycles after pop.
REQ-039 REAL_COEFF[0]=0, IMAG_COEFF[0]=1<<FRAC_BITS, input (2,7) -> output (-7,2) (multiply by j).
REQ-040 DECIM=8, 32 samples continuously available -> exactly 4 output pairs, one per 8 pops; no pop during MAC/WRITE.
REQ-041 real_full=1 held 10 cycles in WRITE -> wr_en low, outputs stable; full released -> single write next cycle.
REQ-042 q_empty=1 while i_empty=0 -> neither rd_en asserts; sample count unchanged.
REQ-043 Coefficient 1<<FRAC_BITS on all taps, inputs max positive -> wraps without macro, equals 2^(DATA_WIDTH-1)-1 with FIR_COMPLEX_SATURATE_EN; reset asserted mid-MAC -> no write, all outputs 0.
